axi_strided_burst_address_generator: RTL and testbench
======================================================

// Module: axi_strided_burst_address_generator
// PURPOSE
// - Issues AXI4 read/write address-channel bursts covering a 2D region: lineCount lines of lineSizeInBytes, line bases lineStrideInBytes apart.
// - Trims the final burst of each line to the exact beat count and splits bursts so none crosses a BOUNDARY_BYTES boundary.
// - Sits between the framebuffer/texture DMA controllers and the AXI interconnect; data channels are handled elsewhere.
// PARAMETERS
// ADDR_WIDTH       32    address, size and stride width in bits
// ID_WIDTH         8     width of axid
// MAX_AxLEN        15    maximum burst length minus one (15 = 16 beats); range 0..255
// AxSIZE           3     log2 bytes per beat (BPB = 2**AxSIZE)
// AxBURST          1     burst type driven on axburst (0 fixed, 1 incr, 2 wrap)
// BOUNDARY_BYTES   4096  no burst may cross a multiple of this value; power of two, >= BPB*(MAX_AxLEN+1)
// LINE_CNT_WIDTH   16    width of lineCount
// PORTS
// aclk               in   1               clock
// resetn             in   1               synchronous active-low reset
// start              in   1               request new transfer; sampled only while done=1
// done               out  1               1 = idle, all bursts handshaken
// startAddr          in   ADDR_WIDTH      base of line 0; low AxSIZE bits ignored (treated as 0)
// lineSizeInBytes    in   ADDR_WIDTH      bytes per line; rounded up to whole beats
// lineStrideInBytes  in   ADDR_WIDTH      line base increment; low AxSIZE bits ignored
// lineCount          in   LINE_CNT_WIDTH  number of lines
// axid               out  ID_WIDTH        constant 0
// axaddr             out  ADDR_WIDTH      burst start address
// axlen              out  8               beats minus one of current burst
// axsize             out  3               constant AxSIZE
// axburst            out  2               constant AxBURST
// axlock/axcache/axprot out 1/4/3         constant 0
// axvalid            out  1               address valid
// axready            in   1               address accepted
// BEHAVIOUR
// - Reset: done=1, axvalid=0, axaddr=0, axlen=0; constants as above. Reset mid-operation aborts: next cycle axvalid=0, done=1, no further bursts.
// - States: IDLE (done=1) and ISSUE (done=0). start while in ISSUE is ignored; start inputs latched only on IDLE accept edge.
// - IDLE, start=1: if lineSizeInBytes==0 or lineCount==0 stay IDLE (no axvalid). Else latch inputs, lineBeats=ceil(lineSizeInBytes/BPB),
//   remBeats=lineBeats, remLines=lineCount, lineBase=addr=startAddr; enter ISSUE; axvalid=1 on the following cycle (1-cycle start latency).
// - Burst length: beats = min(MAX_AxLEN+1, remBeats, (BOUNDARY_BYTES - (addr mod BOUNDARY_BYTES))/BPB); axlen = beats-1, registered with axaddr.
// - AXI rule: once axvalid=1, axaddr/axlen/axvalid hold until axvalid&&axready; no combinational path from axready to outputs.
// - On handshake (ISSUE, axvalid&&axready), registered at that edge:
//   remBeats>beats: addr+=beats*BPB, remBeats-=beats, next burst presented the following cycle (back-to-back, no bubble).
//   else remLines>1: lineBase+=stride, addr=lineBase(new), remBeats=lineBeats, remLines-=1, next burst presented the following cycle.
//   else: axvalid=0, done=1 (IDLE); a new start is accepted from the next cycle.
// - Arithmetic: address/stride sums wrap modulo 2**ADDR_WIDTH; beat counters are ADDR_WIDTH-AxSIZE+1 bits; burst length recomputed from the
//   registered next address (one pipeline register between counters and axaddr/axlen to meet timing).
// - Throughput: one burst per cycle while axready=1.
// TESTING
// - BPB=8, MAX_AxLEN=15: start 0x1000, size 256, 1 line -> (0x1000,len15),(0x1080,len15), then done=1.
// - Size 100, 1 line at 0x2000 -> 13 beats: single burst (0x2000,len12), done.
// - 4K split: start 0x0FC0, size 256 -> (0x0FC0,len7),(0x1000,len15),(0x1080,len7).
// - 2D: 3 lines of 64 B, stride 0x400, start 0x2000 -> (0x2000,len7),(0x2400,len7),(0x2800,len7), done.
// - axready low 5 cycles on burst 2 with start pulses -> axaddr/axlen stable, start ignored, burst sequence unchanged.
// - size 0 or lineCount 0 -> done stays 1, axvalid never asserted; resetn low mid-transfer -> axvalid=0, done=1 next cycle.

Source files
------------

// File: rtl/axi_strided_burst_address_generator_if.sv
// AXI4 read/write address-channel bundle used by the strided burst generator.
interface axi_strided_burst_address_generator_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]   axid;
    logic [ADDR_WIDTH-1:0] axaddr;
    logic [7:0]            axlen;
    logic [2:0]            axsize;
    logic [1:0]            axburst;
    logic                  axlock;
    logic [3:0]            axcache;
    logic [2:0]            axprot;
    logic                  axvalid;
    logic                  axready;

    modport master (
        output axid, axaddr, axlen, axsize, axburst, axlock, axcache, axprot, axvalid,
        input  axready
    );

    modport slave (
        input  axid, axaddr, axlen, axsize, axburst, axlock, axcache, axprot, axvalid,
        output axready
    );
endinterface

// File: rtl/axi_strided_burst_address_generator.sv
// Walks a 2D region (lineCount lines, lineStrideInBytes apart) and issues AXI
// address bursts, trimming each line's last burst and splitting at boundaries.
module axi_strided_burst_address_generator #(
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_WIDTH       = 8,
    parameter int MAX_AxLEN      = 15,
    parameter int AxSIZE         = 3,
    parameter int AxBURST        = 1,
    parameter int BOUNDARY_BYTES = 4096,
    parameter int LINE_CNT_WIDTH = 16
) (
    input  logic                      aclk,
    input  logic                      resetn,
    input  logic                      start,
    output logic                      done,
    input  logic [ADDR_WIDTH-1:0]     startAddr,
    input  logic [ADDR_WIDTH-1:0]     lineSizeInBytes,
    input  logic [ADDR_WIDTH-1:0]     lineStrideInBytes,
    input  logic [LINE_CNT_WIDTH-1:0] lineCount,
    axi_strided_burst_address_generator_if.master ax
);
    localparam int BPB = 1 << AxSIZE;
    localparam int CW  = ADDR_WIDTH - AxSIZE + 1;
    localparam int BW  = $clog2(BOUNDARY_BYTES);
    localparam logic [CW-1:0]         MAXB     = CW'(MAX_AxLEN + 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_MSK = ~ADDR_WIDTH'(BPB - 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                    state;
    logic [ADDR_WIDTH-1:0]     line_base, stride;
    logic [CW-1:0]             line_beats, rem_beats;
    logic [LINE_CNT_WIDTH-1:0] rem_lines;

    logic [ADDR_WIDTH-1:0] start_addr_al, step_addr, next_base;
    logic [CW-1:0]         start_beats, cur_beats, rem_step;
    logic                  more_beats;

    // Burst length limited by max burst, beats left in the line, and the
    // distance to the next boundary; rem is always >= 1 when called.
    function automatic logic [7:0] calc_len(input logic [ADDR_WIDTH-1:0] a,
                                            input logic [CW-1:0] rem);
        logic [BW:0]   bnd_bytes;
        logic [CW-1:0] bnd_beats, b;
        bnd_bytes = (BW+1)'(BOUNDARY_BYTES) - {1'b0, a[BW-1:0]};
        bnd_beats = CW'(bnd_bytes >> AxSIZE);
        b = MAXB;
        if (rem < b)       b = rem;
        if (bnd_beats < b) b = bnd_beats;
        return 8'(b - CW'(1));
    endfunction

    // Next-burst candidates derived from the currently presented burst.
    always_comb begin
        start_addr_al = startAddr & BEAT_MSK;
        start_beats   = CW'(({1'b0, lineSizeInBytes} + (ADDR_WIDTH+1)'(BPB - 1)) >> AxSIZE);
        cur_beats     = CW'(ax.axlen) + CW'(1);
        step_addr     = ax.axaddr + (ADDR_WIDTH'(cur_beats) << AxSIZE);
        rem_step      = rem_beats - cur_beats;
        next_base     = line_base + stride;
        more_beats    = rem_beats > cur_beats;
    end

    assign ax.axid    = '0;
    assign ax.axsize  = 3'(AxSIZE);
    assign ax.axburst = 2'(AxBURST);
    assign ax.axlock  = 1'b0;
    assign ax.axcache = 4'd0;
    assign ax.axprot  = 3'd0;

    // Control FSM; axaddr/axlen are registered so axready never reaches outputs combinationally.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state      <= IDLE;
            done       <= 1'b1;
            ax.axvalid <= 1'b0;
            ax.axaddr  <= '0;
            ax.axlen   <= '0;
            line_base  <= '0;
            stride     <= '0;
            line_beats <= '0;
            rem_beats  <= '0;
            rem_lines  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && lineSizeInBytes != '0 && lineCount != '0) begin
                        state      <= ISSUE;
                        done       <= 1'b0;
                        ax.axvalid <= 1'b1;
                        ax.axaddr  <= start_addr_al;
                        ax.axlen   <= calc_len(start_addr_al, start_beats);
                        line_base  <= start_addr_al;
                        stride     <= lineStrideInBytes & BEAT_MSK;
                        line_beats <= start_beats;
                        rem_beats  <= start_beats;
                        rem_lines  <= lineCount;
                    end
                end
                ISSUE: begin
                    if (ax.axvalid && ax.axready) begin
                        if (more_beats) begin
                            ax.axaddr <= step_addr;
                            ax.axlen  <= calc_len(step_addr, rem_step);
                            rem_beats <= rem_step;
                        end else if (rem_lines > LINE_CNT_WIDTH'(1)) begin
                            ax.axaddr <= next_base;
                            ax.axlen  <= calc_len(next_base, line_beats);
                            line_base <= next_base;
                            rem_beats <= line_beats;
                            rem_lines <= rem_lines - LINE_CNT_WIDTH'(1);
                        end else begin
                            state      <= IDLE;
                            done       <= 1'b1;
                            ax.axvalid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_strided_burst_address_generator.sv
// Directed bench for the strided burst address generator (BPB=8, 16-beat max, 4 KiB boundary).
module tb_axi_strided_burst_address_generator;
    logic        aclk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        done;
    logic [31:0] startAddr = '0;
    logic [31:0] lineSizeInBytes = '0;
    logic [31:0] lineStrideInBytes = '0;
    logic [15:0] lineCount = '0;

    int n_chk = 0;
    int n_fail = 0;
    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];

    always #5 aclk = ~aclk;

    axi_strided_burst_address_generator_if #(.ADDR_WIDTH(32), .ID_WIDTH(8)) bus ();

    axi_strided_burst_address_generator dut (
        .aclk              (aclk),
        .resetn            (resetn),
        .start             (start),
        .done              (done),
        .startAddr         (startAddr),
        .lineSizeInBytes   (lineSizeInBytes),
        .lineStrideInBytes (lineStrideInBytes),
        .lineCount         (lineCount),
        .ax                (bus.master)
    );

    // Record every burst that will handshake on the coming rising edge.
    always @(negedge aclk) begin
        if (resetn && bus.axvalid && bus.axready)
            got_q.push_back({24'd0, bus.axaddr, bus.axlen});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] b(input logic [31:0] a, input logic [7:0] l);
        return {24'd0, a, l};
    endfunction

    task automatic go(input logic [31:0] a, input logic [31:0] sz,
                      input logic [31:0] st, input logic [15:0] lc);
        @(posedge aclk); #1;
        startAddr = a; lineSizeInBytes = sz; lineStrideInBytes = st; lineCount = lc;
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300 && !done; i++) @(negedge aclk);
        chk({tag, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_cnt"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) chk($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bus.axready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_done",  64'(done), 64'd1);
        chk("rst_valid", 64'(bus.axvalid), 64'd0);
        chk("rst_addr",  64'(bus.axaddr), 64'd0);
        chk("rst_len",   64'(bus.axlen), 64'd0);
        chk("rst_size",  64'(bus.axsize), 64'd3);
        chk("rst_burst", 64'(bus.axburst), 64'd1);
        chk("rst_id",    64'(bus.axid), 64'd0);
        chk("rst_misc",  64'({bus.axlock, bus.axcache, bus.axprot}), 64'd0);
        resetn = 1'b1;

        // 256 B single line: two full bursts
        go(32'h1000, 256, 0, 1);
        wait_done("t1");
        exp_q.push_back(b(32'h1000, 15)); exp_q.push_back(b(32'h1080, 15));
        cmp_q("t1");

        // 100 B -> 13 beats in one burst
        go(32'h2000, 100, 0, 1);
        wait_done("t2");
        exp_q.push_back(b(32'h2000, 12));
        cmp_q("t2");

        // 4 KiB boundary split
        go(32'h0FC0, 256, 0, 1);
        wait_done("t3");
        exp_q.push_back(b(32'h0FC0, 7)); exp_q.push_back(b(32'h1000, 15));
        exp_q.push_back(b(32'h1080, 7));
        cmp_q("t3");

        // 2D: three lines of 64 B
        go(32'h2000, 64, 32'h400, 3);
        wait_done("t4");
        exp_q.push_back(b(32'h2000, 7)); exp_q.push_back(b(32'h2400, 7));
        exp_q.push_back(b(32'h2800, 7));
        cmp_q("t4");

        // Stall burst 2 for 5 cycles while pulsing start with other inputs
        bus.axready = 1'b0;
        go(32'h2000, 64, 32'h400, 3);
        chk("st_v0", 64'(bus.axvalid), 64'd1);
        bus.axready = 1'b1;
        @(posedge aclk); #1;
        bus.axready = 1'b0;
        startAddr = 32'h9000; lineSizeInBytes = 32; lineCount = 1;
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            @(posedge aclk); #1;
            chk($sformatf("st_addr%0d", i), 64'(bus.axaddr), 64'h2400);
            chk($sformatf("st_len%0d", i), 64'(bus.axlen), 64'd7);
            chk($sformatf("st_vld%0d", i), 64'(bus.axvalid), 64'd1);
        end
        start = 1'b0;
        bus.axready = 1'b1;
        wait_done("st");
        exp_q.push_back(b(32'h2000, 7)); exp_q.push_back(b(32'h2400, 7));
        exp_q.push_back(b(32'h2800, 7));
        cmp_q("st");
        repeat (4) @(negedge aclk);
        chk("st_idle", 64'({done, bus.axvalid}), 64'b10);

        // Zero size and zero line count are rejected
        go(32'h3000, 0, 8, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk($sformatf("zsz_%0d", i), 64'({done, bus.axvalid}), 64'b10);
        end
        go(32'h3000, 64, 8, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk($sformatf("zlc_%0d", i), 64'({done, bus.axvalid}), 64'b10);
        end
        chk("z_bursts", 64'(got_q.size()), 64'd0);

        // Reset in the middle of a long transfer
        go(32'h4000, 256, 32'h1000, 4);
        repeat (3) @(posedge aclk);
        #1;
        resetn = 1'b0;
        @(posedge aclk); #1;
        chk("mr_valid", 64'(bus.axvalid), 64'd0);
        chk("mr_done",  64'(done), 64'd1);
        resetn = 1'b1;
        got_q.delete();
        repeat (4) @(negedge aclk);
        chk("mr_idle", 64'({done, bus.axvalid}), 64'b10);
        chk("mr_bursts", 64'(got_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
